universal_shift_reg_n: RTL

Parametrised successor to the team's 4-bit universal shift register. Performs WIDTH-bit hold, parallel load, logical shift, rotate and arithmetic shift operations. Multi-bit shifts run one bit per clock under a start/busy/done handshake. Sits in the Registers library as the general-purpose shifter for serial-link and datapath blocks.

---
 rtl/usr_pkg.sv | 17 +
 rtl/usr_shift_step.sv | 30 +++
 rtl/universal_shift_reg_n.sv | 134 +++++++++++++
 3 files changed

// File: rtl/usr_pkg.sv
// Shared definitions for universal_shift_reg_n: mode codes and FSM states.
package usr_pkg;

    localparam logic [2:0] USR_NOP  = 3'b000;
    localparam logic [2:0] USR_SHR  = 3'b001;
    localparam logic [2:0] USR_SHL  = 3'b010;
    localparam logic [2:0] USR_LOAD = 3'b011;
    localparam logic [2:0] USR_ROR  = 3'b100;
    localparam logic [2:0] USR_ROL  = 3'b101;
    localparam logic [2:0] USR_ASR  = 3'b110;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } usr_state_e;

endpackage

// File: rtl/usr_shift_step.sv
// Combinational single-bit step of a universal shifter.
// Non-shift modes pass the value through and report a zero shifted-out bit.
module usr_shift_step
    import usr_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] val,
    input  logic [2:0]       mode,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] nxt,
    output logic             out_bit
);

    // One step of the selected operation; out_bit is the bit leaving the register.
    always_comb begin
        nxt     = val;
        out_bit = 1'b0;
        case (mode)
            USR_SHR: begin nxt = {msb_in, val[WIDTH-1:1]};       out_bit = val[0];       end
            USR_SHL: begin nxt = {val[WIDTH-2:0], lsb_in};       out_bit = val[WIDTH-1]; end
            USR_ROR: begin nxt = {val[0], val[WIDTH-1:1]};       out_bit = val[0];       end
            USR_ROL: begin nxt = {val[WIDTH-2:0], val[WIDTH-1]}; out_bit = val[WIDTH-1]; end
            USR_ASR: begin nxt = {val[WIDTH-1], val[WIDTH-1:1]}; out_bit = val[0];       end
            default: ;
        endcase
    end

endmodule

// File: rtl/universal_shift_reg_n.sv
// WIDTH-bit universal shift register with load/shift/rotate/arith-shift.
// Multi-bit shifts advance one bit per clock under start/busy/done.
// Optional macro USR_CARRY_EN adds a carry output holding the last bit shifted out.
module universal_shift_reg_n
    import usr_pkg::*;
#(
    parameter int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       mode,
    input  logic [CNT_W-1:0] amt,
    input  logic [WIDTH-1:0] i_par,
    input  logic             msb_in,
    input  logic             lsb_in,
    output logic [WIDTH-1:0] a_par,
    output logic             busy,
`ifdef USR_CARRY_EN
    output logic             done,
    output logic             carry
`else
    output logic             done
`endif
);

    usr_state_e       state_q, state_d;
    logic [2:0]       mode_q, mode_d;
    logic [CNT_W-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] step_nxt;
    logic             step_cout;
    logic [CNT_W-1:0] amt_clamped;

    // The step unit only ever runs the latched mode of the command in flight.
    usr_shift_step #(.WIDTH(WIDTH)) u_step (
        .val     (a_q),
        .mode    (mode_q),
        .msb_in  (msb_in),
        .lsb_in  (lsb_in),
        .nxt     (step_nxt),
        .out_bit (step_cout)
    );

    assign amt_clamped = (amt > CNT_W'(WIDTH)) ? CNT_W'(WIDTH) : amt;

`ifdef USR_CARRY_EN
    logic carry_q, carry_d;
`else
    wire unused_cout = step_cout;
`endif

    // Next-state: command acceptance in IDLE, one step per edge in SHIFT.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        rem_d   = rem_q;
        a_d     = a_q;
        done_d  = 1'b0;
`ifdef USR_CARRY_EN
        carry_d = carry_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (mode)
                        USR_LOAD: begin
                            a_d    = i_par;
                            done_d = 1'b1;
`ifdef USR_CARRY_EN
                            carry_d = 1'b0;
`endif
                        end
                        USR_SHR, USR_SHL, USR_ROR, USR_ROL, USR_ASR: begin
                            if (amt == '0) begin
                                done_d = 1'b1;
                            end else begin
                                mode_d  = mode;
                                rem_d   = amt_clamped;
                                state_d = ST_SHIFT;
                            end
                        end
                        default: done_d = 1'b1;
                    endcase
                end
            end
            ST_SHIFT: begin
                a_d   = step_nxt;
                rem_d = rem_q - CNT_W'(1);
`ifdef USR_CARRY_EN
                carry_d = step_cout;
`endif
                if (rem_q == CNT_W'(1)) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State registers; reset aborts any command in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            mode_q  <= USR_NOP;
            rem_q   <= '0;
            a_q     <= '0;
            done_q  <= 1'b0;
`ifdef USR_CARRY_EN
            carry_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            rem_q   <= rem_d;
            a_q     <= a_d;
            done_q  <= done_d;
`ifdef USR_CARRY_EN
            carry_q <= carry_d;
`endif
        end
    end

    assign a_par = a_q;
    assign busy  = (state_q == ST_SHIFT);
    assign done  = done_q;
`ifdef USR_CARRY_EN
    assign carry = carry_q;
`endif

endmodule
